// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the program-counter slice.
//   PC_WIDTH        : program counter width in bits
//   RET_STACK_DEPTH : number of hardware return-stack entries
//   RESET_VECTOR    : PC value loaded by reset
//   pc_sel_t        : priority-select encoding for the PC next-value mux
package cpu_pkg;

  localparam int PC_WIDTH        = 16;
  localparam int RET_STACK_DEPTH = 4;
  localparam logic [PC_WIDTH-1:0] RESET_VECTOR = 16'h0000;

  typedef enum logic [1:0] {
    PC_SEL_HOLD = 2'd0,
    PC_SEL_INC  = 2'd1,
    PC_SEL_LOAD = 2'd2,
    PC_SEL_RET  = 2'd3
  } pc_sel_t;

endpackage

// File: rtl/ret_stack.sv
// LIFO return-address stack.
//   clk, rst_n : clock, synchronous active-low reset (clears the pointer only)
//   push, din  : write din on top of the stack (ignored when full)
//   pop        : discard the top entry (ignored when empty)
//   dout       : current top entry (meaningless while empty)
//   sp         : entry count, 0..DEPTH
//   empty/full : sp == 0 / sp == DEPTH
//   overflow   : push attempted while full (combinational pulse)
//   underflow  : pop attempted while empty (combinational pulse)
// DEPTH must be a power of two, >= 2. push and pop must not both be high.
module ret_stack #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16,
  localparam int SP_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [SP_W-1:0]  sp,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [SP_W-1:0] SP_ONE  = SP_W'(1);
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(DEPTH);
  localparam logic [SP_W-2:0] IDX_ONE = (SP_W - 1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [SP_W-2:0]  wr_idx;
  logic [SP_W-2:0]  top_idx;

  assign empty     = (sp == '0);
  assign full      = (sp == SP_FULL);
  assign overflow  = push && full;
  assign underflow = pop && empty;

  // Low bits of sp address the next free slot; when full they wrap, but no
  // write happens then.
  assign wr_idx  = sp[SP_W-2:0];
  assign top_idx = wr_idx - IDX_ONE;
  assign dout    = mem[top_idx];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sp <= '0;
    end else if (push && !full) begin
      sp <= sp + SP_ONE;
    end else if (pop && !empty) begin
      sp <= sp - SP_ONE;
    end
  end

  // NOTE: the entry storage has no reset; sp alone defines which entries are
  // valid, so clearing the array would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_idx] <= din;
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: PC register, return stack and databus byte driver.
//   clk, rst_n  : clock, synchronous active-low reset
//   inc         : advance PC by one
//   load, pcin  : jump taken (jump unit pcoe) and its target (jump unit pcout)
//   call        : marks a load as a subroutine call (push current PC)
//   ret         : pop the return stack into the PC
//   oe_lo/oe_hi : put PC low/high byte on dataout (oe_hi wins)
//   pc          : registered program counter
//   dataout     : selected PC byte, 8'h00 when no output enable
//   stack_empty/stack_full : return-stack occupancy flags
//   stack_err   : sticky overflow/underflow flag, cleared only by reset
// Next-PC priority: ret > load > inc > hold.
module pc_unit
  import cpu_pkg::*;
#(
  parameter int WIDTH       = PC_WIDTH,
  parameter int STACK_DEPTH = RET_STACK_DEPTH,
  parameter logic [WIDTH-1:0] RESET_VECTOR = cpu_pkg::RESET_VECTOR
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             load,
  input  logic [WIDTH-1:0] pcin,
  input  logic             call,
  input  logic             ret,
  input  logic             oe_lo,
  input  logic             oe_hi,
  output logic [WIDTH-1:0] pc,
  output logic [7:0]       dataout,
  output logic             stack_empty,
  output logic             stack_full,
  output logic             stack_err
);

  localparam int SP_W = $clog2(STACK_DEPTH) + 1;
  localparam logic [WIDTH-1:0] PC_ONE = WIDTH'(1);

  pc_sel_t          pc_sel;
  logic [WIDTH-1:0] pc_next;
  logic [WIDTH-1:0] stack_top;
  logic [SP_W-1:0]  sp;
  logic             push;
  logic             overflow;
  logic             underflow;

  // A call only pushes when the jump is actually taken and no return
  // pre-empts it, so push and pop are mutually exclusive.
  assign push = load && call && !ret;

  ret_stack #(
    .DEPTH (STACK_DEPTH),
    .WIDTH (WIDTH)
  ) u_stack (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (ret),
    .din       (pc),
    .dout      (stack_top),
    .sp        (sp),
    .empty     (stack_empty),
    .full      (stack_full),
    .overflow  (overflow),
    .underflow (underflow)
  );

  // NOTE: every always_comb output gets a default first so no path through
  // the block leaves it unassigned and infers a latch.
  always_comb begin
    pc_sel = PC_SEL_HOLD;
    if (ret) begin
      pc_sel = PC_SEL_RET;
    end else if (load) begin
      pc_sel = PC_SEL_LOAD;
    end else if (inc) begin
      pc_sel = PC_SEL_INC;
    end
  end

  always_comb begin
    pc_next = pc;
    unique case (pc_sel)
      PC_SEL_HOLD: pc_next = pc;
      PC_SEL_INC:  pc_next = pc + PC_ONE;
      PC_SEL_LOAD: pc_next = pcin;
      // Underflowing return leaves the PC where it is.
      PC_SEL_RET:  pc_next = stack_empty ? pc : stack_top;
      default:     pc_next = pc;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc        <= RESET_VECTOR;
      stack_err <= 1'b0;
    end else begin
      pc <= pc_next;
      if (overflow || underflow) begin
        stack_err <= 1'b1;
      end
    end
  end

  always_comb begin
    dataout = 8'h00;
    if (oe_hi) begin
      dataout = pc[15:8];
    end else if (oe_lo) begin
      dataout = pc[7:0];
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        inc, load, call, ret, oe_lo, oe_hi;
  logic [15:0] pcin;
  logic [15:0] pc;
  logic [7:0]  dataout;
  logic        stack_empty, stack_full, stack_err;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pc_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .inc         (inc),
    .load        (load),
    .pcin        (pcin),
    .call        (call),
    .ret         (ret),
    .oe_lo       (oe_lo),
    .oe_hi       (oe_hi),
    .pc          (pc),
    .dataout     (dataout),
    .stack_empty (stack_empty),
    .stack_full  (stack_full),
    .stack_err   (stack_err)
  );

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    n_cmp++;
    assert (observed === expected) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // One clock edge, then settle before the caller samples outputs.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    inc = 0; load = 0; call = 0; ret = 0;
  endtask

  task automatic do_load(input logic [15:0] target, input logic is_call);
    idle();
    load = 1; call = is_call; pcin = target;
    step();
    idle();
  endtask

  task automatic do_ret();
    idle();
    ret = 1;
    step();
    idle();
  endtask

  initial begin
    rst_n = 0; pcin = 16'h0; oe_lo = 0; oe_hi = 0;
    idle();
    step();
    check("rst_pc", pc, 16'h0000);
    check("rst_empty", stack_empty, 1'b1);
    check("rst_full", stack_full, 1'b0);
    check("rst_err", stack_err, 1'b0);
    check("rst_dataout", dataout, 8'h00);

    // Increment sequence and wrap.
    rst_n = 1; inc = 1;
    step(); check("inc1", pc, 16'h0001);
    step(); check("inc2", pc, 16'h0002);
    step(); check("inc3", pc, 16'h0003);
    do_load(16'hFFFF, 0);
    check("load_ffff", pc, 16'hFFFF);
    inc = 1; step(); inc = 0;
    check("inc_wrap", pc, 16'h0000);

    // Plain jump and databus byte select.
    do_load(16'h0010, 0);
    check("load_0010", pc, 16'h0010);
    do_load(16'h1234, 0);
    check("load_1234", pc, 16'h1234);
    check("load_sp", dut.u_stack.sp, 3'd0);
    oe_hi = 1; #1; check("oe_hi", dataout, 8'h12);
    oe_hi = 0; oe_lo = 1; #1; check("oe_lo", dataout, 8'h34);
    oe_hi = 1; #1; check("oe_both", dataout, 8'h12);
    oe_hi = 0; oe_lo = 0; #1; check("oe_none", dataout, 8'h00);

    // Nested call/ret.
    do_load(16'h0100, 0);
    do_load(16'h2000, 1);
    check("call1_pc", pc, 16'h2000);
    check("call1_sp", dut.u_stack.sp, 3'd1);
    check("call1_empty", stack_empty, 1'b0);
    do_load(16'h2005, 0);
    do_load(16'h3000, 1);
    check("call2_pc", pc, 16'h3000);
    check("call2_sp", dut.u_stack.sp, 3'd2);
    do_ret();
    check("ret1_pc", pc, 16'h2005);
    check("ret1_sp", dut.u_stack.sp, 3'd1);
    do_ret();
    check("ret2_pc", pc, 16'h0100);
    check("ret2_empty", stack_empty, 1'b1);
    check("ret2_err", stack_err, 1'b0);

    // Fill, overflow, then unwind in reverse.
    do_load(16'hA000, 1);
    do_load(16'hA001, 1);
    do_load(16'hA002, 1);
    check("fill3_full", stack_full, 1'b0);
    do_load(16'hA003, 1);
    check("fill4_full", stack_full, 1'b1);
    check("fill4_err", stack_err, 1'b0);
    do_load(16'h4444, 1);
    check("ovf_pc", pc, 16'h4444);
    check("ovf_sp", dut.u_stack.sp, 3'd4);
    check("ovf_err", stack_err, 1'b1);
    do_ret(); check("unwind1", pc, 16'hA002);
    do_ret(); check("unwind2", pc, 16'hA001);
    do_ret(); check("unwind3", pc, 16'hA000);
    do_ret(); check("unwind4", pc, 16'h0100);
    check("unwind_empty", stack_empty, 1'b1);
    check("unwind_err_sticky", stack_err, 1'b1);

    // Clear the sticky flag, then underflow.
    rst_n = 0; step(); rst_n = 1;
    check("rst2_err", stack_err, 1'b0);
    do_load(16'h0055, 0);
    do_ret();
    check("unf_pc", pc, 16'h0055);
    check("unf_sp", dut.u_stack.sp, 3'd0);
    check("unf_err", stack_err, 1'b1);

    // Call without load: no push, PC follows inc.
    call = 1; inc = 1; step(); idle();
    check("call_nl_pc", pc, 16'h0056);
    check("call_nl_empty", stack_empty, 1'b1);

    // ret beats load and inc in the same cycle.
    do_load(16'h0ABC, 0);
    do_load(16'h0DEF, 1);
    check("pre_prio_sp", dut.u_stack.sp, 3'd1);
    ret = 1; load = 1; inc = 1; call = 1; pcin = 16'h1111;
    step(); idle();
    check("prio_pc", pc, 16'h0ABC);
    check("prio_sp", dut.u_stack.sp, 3'd0);

    // Reset mid-sequence overrides active load/inc/call.
    do_load(16'h0B00, 1);
    do_load(16'h0B10, 1);
    do_load(16'h0B20, 1);
    check("pre_rst_sp", dut.u_stack.sp, 3'd3);
    check("pre_rst_err", stack_err, 1'b1);
    rst_n = 0; load = 1; inc = 1; call = 1; pcin = 16'h7777;
    step(); idle(); rst_n = 1;
    check("rst3_pc", pc, 16'h0000);
    check("rst3_sp", dut.u_stack.sp, 3'd0);
    check("rst3_err", stack_err, 1'b0);
    check("rst3_empty", stack_empty, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
